// File: rtl/req_capture.sv
// req_capture: request front end for a 4-input priority encoder.
//
// Each raw button line is brought into the clock domain through a two-flop
// synchroniser and then debounced. A debounced rising edge latches the
// channel into the pending vector, which feeds the encoder. The downstream
// logic retires one pending bit per cycle by strobing clr_valid with the
// serviced index. A request that arrives while the same channel is still
// pending, and is not being retired on that edge, raises a sticky overrun flag.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, clears all state
//   btn[3:0]   raw asynchronous request lines, active high
//   clr_valid  one-cycle qualifier for clr_idx
//   clr_idx    index of the pending bit to retire
//   pend[3:0]  pending-request vector (encoder IN)
//   db[3:0]    debounced level of each btn line
//   ovr[3:0]   sticky per-channel overrun flags
//
// Parameters
//   DB_CYCLES  consecutive disagreeing cycles before db follows the input,
//              legal range 1 .. 2**CNT_W-1
//   CNT_W      width of each per-channel debounce counter

module req_capture #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       clr_valid,
    input  logic [1:0] clr_idx,
    output logic [3:0] pend,
    output logic [3:0] db,
    output logic [3:0] ovr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [CNT_W-1:0] cnt     [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [3:0]       db_nxt;
    logic [3:0]       rise;
    logic [3:0]       clr;
    logic [3:0]       pend_nxt;
    logic [3:0]       ovr_nxt;

    // Stage p0/p1: two-flop synchroniser; only sync_p1 is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: the counter only advances while the synchronised input
    // disagrees with the debounced level, so one agreeing cycle restarts it.
    always_comb begin
        db_nxt = db;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (sync_p1[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = sync_p1[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending / overrun update. A set on the same edge as a clear wins so a
    // fresh request is never dropped; that case is also not an overrun since
    // the earlier request is being retired on this very edge.
    always_comb begin
        rise = db_nxt & ~db;
        for (int i = 0; i < 4; i++) begin
            clr[i] = clr_valid && (clr_idx == 2'(i));
        end
        pend_nxt = (pend & ~clr) | rise;
        ovr_nxt  = ovr | (rise & pend & ~clr);
    end

    // Stage p2: debounce counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            db   <= '0;
            pend <= '0;
            ovr  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            db   <= db_nxt;
            pend <= pend_nxt;
            ovr  <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_req_capture.sv
module tb_req_capture;

    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       clr_valid = 1'b0;
    logic [1:0] clr_idx = 2'd0;
    logic [3:0] pend;
    logic [3:0] db;
    logic [3:0] ovr;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0] mdb;
    logic [3:0] mpend;
    logic [3:0] movr;
    logic [3:0] bq0;        // btn seen one edge ago
    logic [3:0] bq1;        // btn seen two edges ago
    logic [7:0] hist [4];   // recent synchronised samples, newest in bit 0
    int         age  [4];   // edges since last level change or reset

    req_capture #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .clr_valid(clr_valid),
        .clr_idx  (clr_idx),
        .pend     (pend),
        .db       (db),
        .ovr      (ovr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdb   = '0;
        mpend = '0;
        movr  = '0;
        bq0   = '0;
        bq1   = '0;
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0;
            age[i]  = 0;
        end
    endtask

    // One clock edge of the specified behaviour: the input is seen two edges
    // late, and a channel's level flips once the last DB_CYCLES samples since
    // its previous flip all disagree with it.
    task automatic model_edge(input logic [3:0] b, input logic cv, input logic [1:0] ci);
        logic [3:0] s2;
        logic [7:0] mask;
        logic [7:0] want;
        logic       flip;
        logic       rise;
        logic       clr;
        s2   = bq1;
        bq1  = bq0;
        bq0  = b;
        mask = 8'((1 << DB_CYCLES) - 1);
        for (int i = 0; i < 4; i++) begin
            age[i]  = age[i] + 1;
            hist[i] = {hist[i][6:0], s2[i]};
            want    = mdb[i] ? 8'h00 : mask;
            flip    = (age[i] >= DB_CYCLES) && ((hist[i] & mask) == want);
            rise    = flip && !mdb[i];
            clr     = cv && (int'(ci) == i);
            if (flip) begin
                mdb[i] = ~mdb[i];
                age[i] = 0;
            end
            if (rise && mpend[i] && !clr) movr[i] = 1'b1;
            if (rise)     mpend[i] = 1'b1;
            else if (clr) mpend[i] = 1'b0;
        end
    endtask

    task automatic cycle(input logic [3:0] b, input logic cv, input logic [1:0] ci);
        btn       = b;
        clr_valid = cv;
        clr_idx   = ci;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(b, cv, ci);
        #1;
        check_eq("db", db, mdb);
        check_eq("pend", pend, mpend);
        check_eq("ovr", ovr, movr);
    endtask

    initial begin
        logic [3:0] rb;
        logic       rcv;
        logic [1:0] rci;

        // Reset, then a single held press on channel 2
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_db", db, 4'b0000);
        check_eq("rst_pend", pend, 4'b0000);
        check_eq("rst_ovr", ovr, 4'b0000);
        for (int j = 0; j < 3; j++) cycle(4'b0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            cycle(4'b0100, 1'b0, 2'd0);
            if (j == 5) check_eq("press_e5_db", db, 4'b0000);
            if (j == 6) begin
                check_eq("press_e6_db", db, 4'b0100);
                check_eq("press_e6_pend", pend, 4'b0100);
                check_eq("press_e6_ovr", ovr, 4'b0000);
            end
        end

        // Glitch of DB_CYCLES-1 cycles on channel 1
        for (int j = 1; j <= 12; j++) begin
            cycle((j <= 3) ? 4'b0110 : 4'b0100, 1'b0, 2'd0);
            check_eq("glitch_db1", db & 4'b0010, 4'b0000);
            check_eq("glitch_pend1", pend & 4'b0010, 4'b0000);
        end
        check_eq("glitch_ovr", ovr, 4'b0000);

        // Service / clear
        for (int j = 0; j < 8; j++) cycle(4'b0101, 1'b0, 2'd0);
        check_eq("svc_pre", pend, 4'b0101);
        cycle(4'b0101, 1'b1, 2'd2);
        check_eq("svc_clr2", pend, 4'b0001);
        cycle(4'b0101, 1'b1, 2'd3);
        check_eq("svc_clr3_noop", pend, 4'b0001);

        // Set/clear collision on channel 0
        for (int j = 0; j < 8; j++) cycle(4'b0000, 1'b0, 2'd0);
        check_eq("coll_pre_db", db, 4'b0000);
        check_eq("coll_pre_pend0", pend & 4'b0001, 4'b0001);
        for (int j = 1; j <= 8; j++) begin
            cycle(4'b0001, (j == 6), 2'd0);
            if (j == 6) begin
                check_eq("coll_db0", db & 4'b0001, 4'b0001);
                check_eq("coll_pend0", pend & 4'b0001, 4'b0001);
                check_eq("coll_ovr0", ovr & 4'b0001, 4'b0000);
            end
        end

        // Overrun on channel 3
        for (int j = 0; j < 8; j++) cycle(4'b1000, 1'b0, 2'd0);
        check_eq("ovr_first", ovr & 4'b1000, 4'b0000);
        for (int j = 0; j < 8; j++) cycle(4'b0000, 1'b0, 2'd0);
        for (int j = 0; j < 8; j++) cycle(4'b1000, 1'b0, 2'd0);
        check_eq("ovr_pend3", pend & 4'b1000, 4'b1000);
        check_eq("ovr_set3", ovr & 4'b1000, 4'b1000);
        cycle(4'b1000, 1'b1, 2'd3);
        check_eq("ovr_clr_pend3", pend & 4'b1000, 4'b0000);
        check_eq("ovr_sticky3", ovr & 4'b1000, 4'b1000);

        // Randomised traffic against the model
        rb = 4'b0000;
        for (int j = 0; j < 400; j++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 11) == 0) rb[k] = ~rb[k];
            end
            rcv = ($urandom_range(0, 3) == 0);
            rci = 2'($urandom_range(0, 3));
            cycle(rb, rcv, rci);
        end

        // Asynchronous reset in the middle of a debounce
        for (int j = 0; j < 8; j++) cycle(4'b0000, 1'b0, 2'd0);
        for (int j = 0; j < 4; j++) cycle(4'b1111, 1'b0, 2'd0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_db", db, 4'b0000);
        check_eq("arst_pend", pend, 4'b0000);
        check_eq("arst_ovr", ovr, 4'b0000);
        for (int j = 0; j < 2; j++) cycle(4'b1111, 1'b0, 2'd0);
        rst_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            cycle(4'b1111, 1'b0, 2'd0);
            if (j == 5) check_eq("arst_e5_db", db, 4'b0000);
            if (j == 6) begin
                check_eq("arst_e6_db", db, 4'b1111);
                check_eq("arst_e6_pend", pend, 4'b1111);
                check_eq("arst_e6_ovr", ovr, 4'b0000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
